// File: rtl/cpu_pipe_pkg.sv
// Shared widths, control-bit positions and the EX/MEM payload layout for the CPU pipeline.
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int WB_W   = 2;
  localparam int M_W    = 2;

  localparam int WB_REGWRITE = 0;
  localparam int M_MEMREAD   = 0;
  localparam int M_MEMWRITE  = 1;

  // Field order matches the concatenation used inside ex_mem_stage.
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [REG_AW-1:0] rd;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-slot skid buffer: an output slot plus one skid slot, with a synchronous flush.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high in the
// preceding cycle. in_ready_o is a register output (!skid_valid) and has no
// combinational path from out_ready_i. Once out_valid_o is high, out_data_o stays
// stable until the beat is taken.
module pipe_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o
);

  logic                 out_valid_q;
  logic                 skid_valid_q;
  logic [PAYLOAD_W-1:0] out_data_q;
  logic [PAYLOAD_W-1:0] skid_data_q;
  logic                 accept;
  logic                 drain;

  assign in_ready_o  = !skid_valid_q;
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_q && out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over accept and drain; payload registers are left as they are.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data_i;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready_o is low while the skid is full, so no accept can race this move.
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_data_q <= in_data_i;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready skid buffering, flush, bubble gating of the
// MEM/WB controls, and the MEM-stage destination register export for forwarding.
module ex_mem_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int REG_AW = cpu_pipe_pkg::REG_AW,
  parameter int WB_W   = cpu_pipe_pkg::WB_W,
  parameter int M_W    = cpu_pipe_pkg::M_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] Address_o,
  output logic [DATA_W-1:0] Write_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] fwd_rd_o
);

  localparam int PAYLOAD_W = WB_W + M_W + 2 * DATA_W + REG_AW;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_valid;
  logic [WB_W-1:0]      wb_q;
  logic [M_W-1:0]       m_q;
  logic [DATA_W-1:0]    alu_q;
  logic [DATA_W-1:0]    store_q;
  logic [REG_AW-1:0]    rd_q;

  assign in_payload = {WB_i, M_i, ALUResult_i, store_data_i, rd_i};

  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_payload)
  );

  assign {wb_q, m_q, alu_q, store_q, rd_q} = out_payload;

  // Controls are gated so a bubble or flushed slot can never write memory or the register file.
  assign out_valid_o  = out_valid;
  assign WB_o         = out_valid ? wb_q : '0;
  assign MemRead_o    = m_q[M_MEMREAD] & out_valid;
  assign MemWrite_o   = m_q[M_MEMWRITE] & out_valid;
  assign Address_o    = alu_q;
  assign Write_data_o = store_q;
  assign rd_o         = rd_q;
  assign fwd_rd_o     = (out_valid && wb_q[WB_REGWRITE]) ? rd_q : '0;

endmodule
